// File: rtl/decrypt_stream_pkg.sv
// decrypt_stream_pkg
// Shared constants and helpers for the nibble-Feistel stream cipher. Both the
// encryption block and decrypt_stream import this, so the round function is
// defined once for the two directions.
//   DATA_W / NIB_W / KEY_W : fixed datapath widths
//   EXP_IDX                : source bit of r for each expansion bit e[i]
//   fold_sum               : nibble sum that closes the round function
package decrypt_stream_pkg;

  localparam int DATA_W = 8;
  localparam int NIB_W  = 4;
  localparam int KEY_W  = 8;

  // e = {r[3], r[0], r[1], r[2], r[1], r[3], r[2], r[0]}; entry i is the r bit
  // that feeds e[i], so index 0 is the rightmost element of that list.
  localparam logic [1:0] EXP_IDX [DATA_W] = '{
    2'd0, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3
  };

  // Sum of the two halves of x plus the key LSB; the carry out is dropped by
  // the 4-bit result width.
  function automatic logic [NIB_W-1:0] fold_sum(input logic [DATA_W-1:0] x,
                                                input logic              k0);
    fold_sum = x[DATA_W-1:NIB_W] + x[NIB_W-1:0] + {{(NIB_W-1){1'b0}}, k0};
  endfunction

endpackage

// File: rtl/round_f.sv
// round_f
// Combinational round function, split into its two halves so a pipeline can
// register x between them.
//   r      in  4 : round input nibble (pass-through low nibble of the byte)
//   k      in  8 : key
//   x      out 8 : expanded nibble XOR key
//   x_held in  8 : an x value, possibly from an earlier cycle, to be folded
//   s      out 4 : fold of x_held; a single-cycle user ties x_held to x
module round_f
  import decrypt_stream_pkg::*;
(
  input  logic [NIB_W-1:0]  r,
  input  logic [KEY_W-1:0]  k,
  output logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] x_held,
  output logic [NIB_W-1:0]  s
);

  logic [DATA_W-1:0] e;

  for (genvar i = 0; i < DATA_W; i++) begin : g_expand
    assign e[i] = r[EXP_IDX[i]];
  end

  assign x = e ^ k;

  // k[0] is still the right key bit for x_held because the key cannot change
  // while any byte is inside the pipeline.
  assign s = fold_sum(x_held, k[0]);

endmodule

// File: rtl/decrypt_stream.sv
// decrypt_stream
// Two-stage valid/ready decryption pipeline with an interlocked key register.
// S1 captures the ciphertext plus x, S2 holds the recovered plaintext and
// drives the output.
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   key_in, key_load       : key value and load request
//   key_busy               : pipeline holds a byte; key loads are ignored
//   in_data/valid/ready    : ciphertext byte handshake
//   out_data/valid/ready   : plaintext byte handshake
//   byte_count             : bytes delivered since reset, wraps at 2^16
module decrypt_stream
  import decrypt_stream_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              key_load,
  output logic              key_busy,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       byte_count
);

  logic [KEY_W-1:0]  key;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [DATA_W-1:0] s1_x;
  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;
  logic [15:0]       count;

  logic [DATA_W-1:0] in_x;
  logic [NIB_W-1:0]  s1_s;
  logic              s2_free;
  logic              s1_free;
  logic              in_fire;

  round_f u_round_f (
    .r      (in_data[NIB_W-1:0]),
    .k      (key),
    .x      (in_x),
    .x_held (s1_x),
    .s      (s1_s)
  );

  // A stage may take new contents when it is empty or its contents leave this
  // cycle; out_ready therefore ripples back to in_ready combinationally.
  assign s2_free  = !s2_valid || out_ready;
  assign s1_free  = !s1_valid || s2_free;
  assign in_ready = !key_load && s1_free;
  assign in_fire  = in_valid && in_ready;
  assign key_busy = s1_valid || s2_valid;

  assign out_data   = s2_data;
  assign out_valid  = s2_valid;
  assign byte_count = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      key      <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_x     <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      count    <= '0;
    end else begin
      // Only an empty pipeline may change key, so every byte sees one key.
      if (key_load && !key_busy) begin
        key <= key_in;
      end

      if (s1_free) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          s1_data <= in_data;
          s1_x    <= in_x;
        end
      end

      // Data is only rewritten when a real byte moves in, so a stalled or
      // drained output keeps its last value.
      if (s2_free) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= {s1_data[DATA_W-1:NIB_W] ^ s1_s, s1_data[NIB_W-1:0]};
        end
      end

      if (s2_valid && out_ready) begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_decrypt_stream.sv
// tb_decrypt_stream
// Self-checking bench for decrypt_stream: a table of hand-computed key/cipher/
// plain vectors plus directed sequences for streaming, backpressure, key
// interlock, mid-stream reset and byte_count wrap.
module tb_decrypt_stream;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  key_in;
  logic        key_load;
  logic        key_busy;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] byte_count;

  always #5 clock = ~clock;

  decrypt_stream dut (
    .clock      (clock),
    .reset      (reset),
    .key_in     (key_in),
    .key_load   (key_load),
    .key_busy   (key_busy),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .byte_count (byte_count)
  );

  typedef struct {
    logic [7:0] key;
    logic [7:0] cipher;
    logic [7:0] expected;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [7:0] got_q [$];
  int         got_cyc [$];
  int         xfer_total = 0;
  bit         mon_store  = 1'b1;

  always @(posedge clock) cycle++;

  // Transfers are recorded mid-cycle, ahead of the edge that completes them.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      xfer_total++;
      if (mon_store) begin
        got_q.push_back(out_data);
        got_cyc.push_back(cycle);
      end
    end
  end

  function automatic logic [7:0] ref_decrypt(input logic [7:0] c, input logic [7:0] k);
    logic [3:0] r;
    logic [7:0] e;
    logic [7:0] x;
    logic [4:0] sum;
    r   = c[3:0];
    e   = {r[3], r[0], r[1], r[2], r[1], r[3], r[2], r[0]};
    x   = e ^ k;
    sum = {1'b0, x[7:4]} + {1'b0, x[3:0]} + {4'b0000, k[0]};
    return {c[7:4] ^ sum[3:0], c[3:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic loadKey(input logic [7:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Key load with a byte offered in the same cycle, then one byte through an
  // otherwise idle pipeline, watching the two-cycle latency.
  task automatic applyStimulus(input vec_t v, input int exp_count);
    out_ready = 1'b1;
    key_in    = v.key;
    key_load  = 1'b1;
    in_data   = v.cipher;
    in_valid  = 1'b1;
    #1;
    checkOutput("load_blocks_in_ready", in_ready, 0);
    tick();
    key_load = 1'b0;
    #1;
    checkOutput("no_accept_on_load", key_busy, 0);
    checkOutput("ready_after_load", in_ready, 1);
    tick();
    in_valid = 1'b0;
    checkOutput("latency_edge1_valid", out_valid, 0);
    tick();
    checkOutput("latency_edge2_valid", out_valid, 1);
    checkOutput("vector_data", out_data, v.expected);
    tick();
    checkOutput("vector_count", byte_count, exp_count);
  endtask

  task automatic sendAndGet(input logic [7:0] c, output logic [7:0] got, output bit ok);
    got_q.delete();
    got_cyc.delete();
    in_data  = c;
    in_valid = 1'b1;
    #1;
    checkOutput("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8 && got_q.size() == 0; i++) tick();
    ok  = (got_q.size() > 0);
    got = ok ? got_q[0] : 8'h00;
  endtask

  initial begin
    vec_t       vecs [3];
    logic [7:0] sent [16];
    logic [7:0] bp [3];
    logic [7:0] got;
    logic [7:0] snap;
    bit         ok;
    bit         have_snap;
    bit         done;
    int         acc;
    int         not_ready;
    int         gaps;
    int         unstable;
    int         xfer_at_reset;
    int         start;

    vecs[0] = '{8'h93, 8'h06, 8'h46};
    vecs[1] = '{8'hAC, 8'h39, 8'hC9};
    vecs[2] = '{8'hFF, 8'hA5, 8'hD5};

    reset     = 1'b1;
    key_in    = 8'h00;
    key_load  = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 8'h00);
    checkOutput("reset_key_busy", key_busy, 0);
    checkOutput("reset_byte_count", byte_count, 0);
    checkOutput("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 3; i++) applyStimulus(vecs[i], i + 1);

    // Key FF is live. A load of 00 while a byte is in flight must be ignored.
    $display("[TB] key interlock while busy");
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    key_in   = 8'h00;
    key_load = 1'b1;
    #1;
    checkOutput("busy_while_in_flight", key_busy, 1);
    checkOutput("busy_load_blocks_ready", in_ready, 0);
    tick();
    key_load = 1'b0;
    repeat (3) tick();
    sendAndGet(8'h06, got, ok);
    checkOutput("old_key_out_seen", ok, 1);
    checkOutput("old_key_kept", got, 8'h26);

    $display("[TB] streaming");
    loadKey(8'h5A);
    got_q.delete();
    got_cyc.delete();
    not_ready = 0;
    for (int i = 0; i < 16; i++) begin
      sent[i]  = 8'(i * 29 + 7);
      in_data  = sent[i];
      in_valid = 1'b1;
      #1;
      if (!in_ready) not_ready++;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    checkOutput("stream_always_ready", not_ready, 0);
    checkOutput("stream_out_count", got_q.size(), 16);
    gaps = 0;
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      checkOutput("stream_data", got_q[i], ref_decrypt(sent[i], 8'h5A));
      if (i > 0 && got_cyc[i] != got_cyc[i-1] + 1) gaps++;
    end
    checkOutput("stream_consecutive", gaps, 0);

    $display("[TB] backpressure");
    bp[0] = 8'h11;
    bp[1] = 8'hE2;
    bp[2] = 8'h7C;
    got_q.delete();
    got_cyc.delete();
    out_ready = 1'b0;
    acc       = 0;
    unstable  = 0;
    have_snap = 1'b0;
    snap      = 8'h00;
    for (int c = 0; c < 5; c++) begin
      in_data  = bp[(acc < 3) ? acc : 2];
      in_valid = 1'b1;
      #1;
      if (out_valid) begin
        if (have_snap && out_data !== snap) unstable++;
        snap      = out_data;
        have_snap = 1'b1;
      end
      if (in_ready) acc++;
      tick();
    end
    #1;
    checkOutput("bp_accepts", acc, 2);
    checkOutput("bp_in_ready_low", in_ready, 0);
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_stall_data", out_data, ref_decrypt(bp[0], 8'h5A));
    checkOutput("bp_stable", unstable, 0);
    out_ready = 1'b1;
    done      = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      in_data  = bp[2];
      in_valid = 1'b1;
      #1;
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checkOutput("bp_third_accepted", done, 1);
    repeat (5) tick();
    checkOutput("bp_out_count", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checkOutput("bp_order", got_q[i], ref_decrypt(bp[i], 8'h5A));
    end

    $display("[TB] reset with both stages full");
    out_ready = 1'b0;
    in_data   = 8'h42;
    in_valid  = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    checkOutput("pre_reset_busy", key_busy, 1);
    checkOutput("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_out_valid", out_valid, 0);
    checkOutput("mid_reset_out_data", out_data, 8'h00);
    checkOutput("mid_reset_busy", key_busy, 0);
    checkOutput("mid_reset_count", byte_count, 0);
    checkOutput("mid_reset_in_ready", in_ready, 1);
    out_ready     = 1'b1;
    xfer_at_reset = xfer_total;
    sendAndGet(8'h06, got, ok);
    checkOutput("zero_key_out_seen", ok, 1);
    checkOutput("zero_key_data", got, 8'hD6);
    checkOutput("count_tracks", byte_count, xfer_total - xfer_at_reset);

    $display("[TB] byte_count wrap");
    mon_store = 1'b0;
    start     = xfer_total;
    in_data   = 8'h3C;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    done      = 1'b0;
    for (int i = 0; i < 70000 && !done; i++) begin
      tick();
      if (byte_count == 16'h0000) done = 1'b1;
    end
    in_valid = 1'b0;
    checkOutput("wrap_reached", done, 1);
    checkOutput("wrap_count_zero", byte_count, 0);
    checkOutput("wrap_transfers", xfer_total - start, 65536 - (start - xfer_at_reset));
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
